// File: rtl/shield_rotation_ctrl.sv
// Shield orientation controller: debounces the rotate buttons and commits
// one orientation step per frame at the start of vertical blanking.
//
// state    | meaning
// IDLE     | no rotation waiting for the next frame tick
// CW_PEND  | clockwise step waiting for the next frame tick
// CCW_PEND | counter-clockwise step waiting for the next frame tick
module shield_rotation_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          ACTIVE_V        = 720
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        btn_cw_in,
    input  logic        btn_ccw_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [1:0]  rotate_out,
    output logic        rotated_out
);

    typedef enum logic [1:0] {IDLE, CW_PEND, CCW_PEND} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_CW, REQ_CCW} req_t;

    // index 0 = clockwise button, index 1 = counter-clockwise button
    logic [1:0]  sync_1;
    logic [1:0]  sync_2;
    logic [1:0]  stable;
    logic [1:0]  stable_d;
    logic [15:0] deb_cnt [2];
    logic [1:0]  press;

    state_t      state, state_next;
    req_t        req, eff_req;
    logic        tick;
    logic [1:0]  rotate_next;
    logic        rotated_next;

    function automatic logic [1:0] step_cw(input logic [1:0] code);
        case (code)
            2'b00:   step_cw = 2'b10;
            2'b10:   step_cw = 2'b01;
            2'b01:   step_cw = 2'b11;
            default: step_cw = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] step_ccw(input logic [1:0] code);
        case (code)
            2'b00:   step_ccw = 2'b11;
            2'b11:   step_ccw = 2'b01;
            2'b01:   step_ccw = 2'b10;
            default: step_ccw = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync_1     <= '0;
            sync_2     <= '0;
            stable     <= '0;
            stable_d   <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_1   <= {btn_ccw_in, btn_cw_in};
            sync_2   <= sync_1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    stable[i]  <= sync_2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign press = stable & ~stable_d;
    assign tick  = (hcount_in == 11'd0) && (vcount_in == 10'(ACTIVE_V));

    always_comb begin
        req          = REQ_NONE;
        eff_req      = REQ_NONE;
        state_next   = state;
        rotate_next  = rotate_out;
        rotated_next = 1'b0;

        // simultaneous presses cancel and leave the pending request alone
        case (press)
            2'b01:   req = REQ_CW;
            2'b10:   req = REQ_CCW;
            default: req = REQ_NONE;
        endcase

        if (req != REQ_NONE) begin
            eff_req = req;
        end else begin
            case (state)
                CW_PEND:  eff_req = REQ_CW;
                CCW_PEND: eff_req = REQ_CCW;
                default:  eff_req = REQ_NONE;
            endcase
        end

        if (tick) begin
            state_next = IDLE;
            if (eff_req == REQ_CW) begin
                rotate_next  = step_cw(rotate_out);
                rotated_next = 1'b1;
            end else if (eff_req == REQ_CCW) begin
                rotate_next  = step_ccw(rotate_out);
                rotated_next = 1'b1;
            end
        end else if (req == REQ_CW) begin
            state_next = CW_PEND;
        end else if (req == REQ_CCW) begin
            state_next = CCW_PEND;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            rotate_out  <= 2'b00;
            rotated_out <= 1'b0;
        end else begin
            state       <= state_next;
            rotate_out  <= rotate_next;
            rotated_out <= rotated_next;
        end
    end

endmodule

// File: tb/tb_shield_rotation_ctrl.sv
// Bench for shield_rotation_ctrl: directed scenarios plus randomized frames,
// checked against a frame-level model (orientation index and last request).
module tb_shield_rotation_ctrl;

    localparam int D = 4;

    logic        clk;
    logic        rst_n;
    logic        btn_cw;
    logic        btn_ccw;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [1:0]  rotate_out;
    logic        rotated_out;

    int errors = 0;
    int checks = 0;
    int orient = 0;  // 0 top, 1 right, 2 bottom, 3 left
    int pend   = 0;  // 0 none, 1 clockwise, 2 counter-clockwise

    shield_rotation_ctrl #(
        .DEBOUNCE_CYCLES(16'(D)),
        .ACTIVE_V       (720)
    ) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .btn_cw_in  (btn_cw),
        .btn_ccw_in (btn_ccw),
        .hcount_in  (hcount),
        .vcount_in  (vcount),
        .rotate_out (rotate_out),
        .rotated_out(rotated_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] code_of(input int o);
        case (o)
            0:       code_of = 2'b00;
            1:       code_of = 2'b10;
            2:       code_of = 2'b01;
            default: code_of = 2'b11;
        endcase
    endfunction

    // Holds the buttons for 'hold' cycles, then releases long enough to settle.
    task automatic press(input logic cw, input logic ccw, input int hold);
        @(negedge clk);
        btn_cw  = cw;
        btn_ccw = ccw;
        repeat (hold) @(negedge clk);
        btn_cw  = 1'b0;
        btn_ccw = 1'b0;
        repeat (D + 8) @(negedge clk);
        if (hold >= D) begin
            if (cw && !ccw) pend = 1;
            else if (ccw && !cw) pend = 2;
        end
    endtask

    task automatic do_tick(input string name);
        logic exp_pulse;
        @(negedge clk);
        hcount = 11'd0;
        vcount = 10'd720;
        exp_pulse = (pend != 0);
        if (pend == 1) orient = (orient + 1) % 4;
        else if (pend == 2) orient = (orient + 3) % 4;
        pend = 0;
        @(negedge clk);
        hcount = 11'd100;
        vcount = 10'd300;
        checks++;
        if (rotate_out !== code_of(orient) || rotated_out !== exp_pulse) begin
            errors++;
            $display("FAIL %s: rotate_out=%b rotated_out=%b, expected %b %b",
                     name, rotate_out, rotated_out, code_of(orient), exp_pulse);
        end
        @(negedge clk);
        checks++;
        if (rotated_out !== 1'b0 || rotate_out !== code_of(orient)) begin
            errors++;
            $display("FAIL %s_after: rotate_out=%b rotated_out=%b, expected %b 0",
                     name, rotate_out, rotated_out, code_of(orient));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rotate_out !== 2'b00 || rotated_out !== 1'b0) begin
            errors++;
            $display("FAIL reset: rotate_out=%b rotated_out=%b, expected 00 0",
                     rotate_out, rotated_out);
        end
        rst_n = 1'b1;
        repeat (D + 4) @(negedge clk);
        for (int i = 0; i < 3; i++) do_tick("idle_tick");
    endtask

    task automatic test_cw_sequence();
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0, 20);
            do_tick("cw_step");
        end
    endtask

    task automatic test_ccw_sequence();
        for (int i = 0; i < 2; i++) begin
            press(1'b0, 1'b1, 20);
            do_tick("ccw_step");
        end
    endtask

    task automatic test_glitch();
        press(1'b1, 1'b0, D - 1);
        do_tick("short_pulse");
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_cw = ~btn_cw;
            @(negedge clk);
        end
        press(1'b1, 1'b0, 20);
        do_tick("bounce_then_hold");
    endtask

    task automatic test_last_wins();
        press(1'b1, 1'b0, 20);
        press(1'b0, 1'b1, 20);
        do_tick("last_press_wins");
        press(1'b1, 1'b1, 20);
        do_tick("both_cancel");
    endtask

    task automatic test_frozen_tick();
        press(1'b1, 1'b0, 20);
        @(negedge clk);
        hcount = 11'd0;
        vcount = 10'd720;
        orient = (orient + 1) % 4;
        pend = 0;
        @(negedge clk);
        checks++;
        if (rotate_out !== code_of(orient) || rotated_out !== 1'b1) begin
            errors++;
            $display("FAIL frozen_first: rotate_out=%b rotated_out=%b, expected %b 1",
                     rotate_out, rotated_out, code_of(orient));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rotate_out !== code_of(orient) || rotated_out !== 1'b0) begin
                errors++;
                $display("FAIL frozen_repeat: rotate_out=%b rotated_out=%b, expected %b 0",
                         rotate_out, rotated_out, code_of(orient));
            end
        end
        hcount = 11'd100;
        vcount = 10'd300;
    endtask

    task automatic test_reset_discard();
        press(1'b1, 1'b0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        orient = 0;
        pend = 0;
        checks++;
        if (rotate_out !== 2'b00 || rotated_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: rotate_out=%b rotated_out=%b, expected 00 0",
                     rotate_out, rotated_out);
        end
        repeat (D + 4) @(negedge clk);
        do_tick("tick_after_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 16; f++) begin
            int n_ev;
            n_ev = $urandom_range(0, 3);
            for (int e = 0; e < n_ev; e++) begin
                logic dir;
                int   hold;
                dir = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) hold = $urandom_range(1, D - 1);
                else hold = $urandom_range(D, D + 12);
                press(dir, ~dir, hold);
            end
            do_tick("random_frame");
        end
    endtask

    initial begin
        btn_cw  = 1'b0;
        btn_ccw = 1'b0;
        hcount  = 11'd100;
        vcount  = 10'd300;
        test_reset();
        test_cw_sequence();
        test_ccw_sequence();
        test_glitch();
        test_last_wins();
        test_frozen_tick();
        test_reset_discard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
